// File: rtl/inj_sched.sv
// inj_sched - injection scheduler between a deflection-router client port and
// NSRC local traffic sources.
//
// Owns the single per-cycle injection slot into the router. Priority order:
// re-injection of deflected/misrouted packets from a 2-entry buffer, then the
// local sources in round-robin order, throttled by a token bucket. Packets
// addressed to this PE are extracted onto the receive port. A local source
// whose destination is this PE is looped back to the receive port without
// using the slot or a token.
//
// Packet format (PW = A_W+D_W+2): [PW-1] valid, [PW-2] deflected,
// [A_W+D_W-1:D_W] address, [D_W-1:0] data.
//
// Ports:
//   clk, rst_n (async active-low), ce (clock enable, 0 freezes all state)
//   o          packet arriving from the router
//   i          registered packet to the router
//   src_req/src_dst/src_data  per-source request, destination, payload
//   src_gnt    one-hot grant (combinational)
//   rx_valid/rx_data          registered delivery to the local PE
//   busy       re-injection buffer non-empty or i valid
//   ovf        sticky: deflected packet dropped because the buffer was full
//   stat_inj/stat_reinj/stat_rx  16-bit saturating event counters
//
// Optional feature: define INJ_SCHED_STATS_EN to build the event counters;
// without it the stat_* outputs are tied to zero.
module inj_sched #(
  parameter int N          = 4,
  parameter int D_W        = 32,
  parameter int A_W        = $clog2(N) + 1,
  parameter int POSX       = 0,
  parameter int NSRC       = 4,
  parameter int TOK_MAX    = 8,
  parameter int TOK_PERIOD = 10,
  parameter int BACKOFF    = 2,
  parameter int WRAP       = 1,
  localparam int PW        = A_W + D_W + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic [PW-1:0]           o,
  output logic [PW-1:0]           i,
  input  logic [NSRC-1:0]         src_req,
  input  logic [NSRC*(A_W-1)-1:0] src_dst,
  input  logic [NSRC*D_W-1:0]     src_data,
  output logic [NSRC-1:0]         src_gnt,
  output logic                    rx_valid,
  output logic [D_W-1:0]          rx_data,
  output logic                    busy,
  output logic                    ovf,
  output logic [15:0]             stat_inj,
  output logic [15:0]             stat_reinj,
  output logic [15:0]             stat_rx
);

  localparam int RR_W = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int TK_W = $clog2(TOK_MAX + 1);
  localparam int RC_W = (TOK_PERIOD > 1) ? $clog2(TOK_PERIOD) : 1;
  localparam int BO_W = (BACKOFF > 0) ? $clog2(BACKOFF + 1) : 1;

  // Control state
  logic [1:0]      fifo_cnt;
  logic            fifo_wr;
  logic            fifo_rd;
  logic [BO_W-1:0] bo_q;
  logic [TK_W-1:0] tok_q;
  logic [RC_W-1:0] rc_q;
  logic [RR_W-1:0] rr_q;

  // Buffer storage (data only, no reset needed)
  logic [A_W+D_W-1:0] fifo_q [2];

  // ---- Stage p0: classify the router packet and decide the slot ----
  logic           vld_p0;
  logic [A_W-1:0] o_addr;
  logic [D_W-1:0] o_data;
  logic           deliver, capture, pop, cap_ok, drop;
  logic           pick_vld;
  logic [RR_W-1:0] pick_idx;
  logic [A_W-2:0] pick_dst;
  logic [D_W-1:0] pick_data;
  logic           pick_lb, local_ok, grant_lb, grant_inj, refill;

  assign vld_p0  = ce & o[PW-1];
  assign o_addr  = o[A_W+D_W-1:D_W];
  assign o_data  = o[D_W-1:0];
  assign deliver = vld_p0 & ~o[PW-2] & (o_addr == A_W'(POSX));
  assign capture = vld_p0 & ~deliver;

  assign pop    = ce & (fifo_cnt != 2'd0) & ((WRAP == 0) || (bo_q == '0));
  // A full buffer still accepts a capture when the head leaves this cycle.
  assign cap_ok = capture & ((fifo_cnt != 2'd2) | pop);
  assign drop   = capture & ~cap_ok;

  // Round-robin search starting at the pointer.
  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int n = 0; n < NSRC; n++) begin
      j = (int'(rr_q) + n) % NSRC;
      if (!pick_vld && src_req[j]) begin
        pick_vld = 1'b1;
        pick_idx = RR_W'(j);
      end
    end
  end

  assign pick_dst  = src_dst[int'(pick_idx)*(A_W-1) +: (A_W-1)];
  assign pick_data = src_data[int'(pick_idx)*D_W +: D_W];
  assign pick_lb   = ({1'b0, pick_dst} == A_W'(POSX));

  assign local_ok  = ce & (fifo_cnt == 2'd0) & ~capture & (tok_q != '0) & pick_vld;
  // Loopback shares the receive port with router delivery; the router wins.
  assign grant_lb  = local_ok & pick_lb & ~deliver;
  assign grant_inj = local_ok & ~pick_lb;

  always_comb begin
    src_gnt = '0;
    if (grant_lb || grant_inj) src_gnt[pick_idx] = 1'b1;
  end

  assign refill = (rc_q == RC_W'(TOK_PERIOD - 1));
  assign busy   = (fifo_cnt != 2'd0) | i[PW-1];

  // ---- Stage p1: registered slot, receive port and bookkeeping ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i        <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      ovf      <= 1'b0;
      fifo_cnt <= 2'd0;
      fifo_wr  <= 1'b0;
      fifo_rd  <= 1'b0;
      bo_q     <= '0;
      tok_q    <= TK_W'(TOK_MAX);
      rc_q     <= '0;
      rr_q     <= '0;
    end else if (ce) begin
      if (pop)            i <= {1'b1, 1'b0, fifo_q[fifo_rd]};
      else if (grant_inj) i <= {1'b1, 1'b0, 1'b0, pick_dst, pick_data};
      else                i <= '0;

      rx_valid <= deliver | grant_lb;
      if (deliver)       rx_data <= o_data;
      else if (grant_lb) rx_data <= pick_data;

      if (cap_ok) fifo_wr <= ~fifo_wr;
      if (pop)    fifo_rd <= ~fifo_rd;
      case ({cap_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      if (drop) ovf <= 1'b1;

      if (pop && (WRAP != 0)) bo_q <= BO_W'(BACKOFF);
      else if (bo_q != '0)    bo_q <= bo_q - BO_W'(1);

      rc_q <= refill ? '0 : rc_q + RC_W'(1);
      case ({refill, grant_inj})
        2'b10:   if (tok_q != TK_W'(TOK_MAX)) tok_q <= tok_q + TK_W'(1);
        2'b01:   tok_q <= tok_q - TK_W'(1);
        default: tok_q <= tok_q;
      endcase

      if (grant_lb || grant_inj)
        rr_q <= (int'(pick_idx) == NSRC - 1) ? '0 : pick_idx + RR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (cap_ok) fifo_q[fifo_wr] <= {o_addr, o_data};
  end

`ifdef INJ_SCHED_STATS_EN
  logic [15:0] st_inj_q, st_reinj_q, st_rx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_inj_q   <= '0;
      st_reinj_q <= '0;
      st_rx_q    <= '0;
    end else if (ce) begin
      if (grant_inj && st_inj_q != 16'hFFFF)               st_inj_q   <= st_inj_q + 16'd1;
      if (pop && st_reinj_q != 16'hFFFF)                   st_reinj_q <= st_reinj_q + 16'd1;
      if ((deliver || grant_lb) && st_rx_q != 16'hFFFF)    st_rx_q    <= st_rx_q + 16'd1;
    end
  end

  assign stat_inj   = st_inj_q;
  assign stat_reinj = st_reinj_q;
  assign stat_rx    = st_rx_q;
`else
  assign stat_inj   = '0;
  assign stat_reinj = '0;
  assign stat_rx    = '0;
`endif

endmodule

// File: tb/tb_inj_sched.sv
// Directed bench for inj_sched (default parameters, POSX=0, WRAP=1).
// A queue-based reference model runs on every falling edge and is compared
// with the DUT outputs; literal expectations pin the key scenarios.
module tb_inj_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic [36:0] o;
  logic [36:0] i;
  logic [3:0]  src_req;
  logic [7:0]  src_dst;
  logic [127:0] src_data;
  logic [3:0]  src_gnt;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        busy, ovf;
  logic [15:0] stat_inj, stat_reinj, stat_rx;

  int total = 0;
  int bad   = 0;

  inj_sched dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .o(o), .i(i),
    .src_req(src_req), .src_dst(src_dst), .src_data(src_data), .src_gnt(src_gnt),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .ovf(ovf),
    .stat_inj(stat_inj), .stat_reinj(stat_reinj), .stat_rx(stat_rx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [36:0] pk(input logic defl, input logic [2:0] a, input logic [31:0] d);
    return {1'b1, defl, a, d};
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed { logic [2:0] a; logic [31:0] d; } pkt_t;
  pkt_t        mq[$];
  int          m_tok, m_rc, m_bo, m_rr;
  logic [36:0] m_i;
  logic        m_rxv, m_ovf;
  logic [31:0] m_rxd;
  logic [3:0]  m_gnt;

  always @(negedge clk) begin : model
    logic dlv, cap, do_pop, lb, inj, refill;
    int   pick;
    pkt_t p;
    if (!rst_n) begin
      mq.delete();
      m_tok = 8; m_rc = 0; m_bo = 0; m_rr = 0;
      m_i = '0; m_rxv = 1'b0; m_rxd = '0; m_ovf = 1'b0;
    end
    dlv    = o[36] && !o[35] && (o[34:32] == 3'd0);
    cap    = o[36] && !dlv;
    do_pop = (mq.size() > 0) && (m_bo == 0);
    pick   = -1; lb = 1'b0; inj = 1'b0; m_gnt = '0;
    if (rst_n && ce && !do_pop && mq.size() == 0 && !cap && m_tok > 0)
      for (int n = 0; n < 4; n++)
        if (pick < 0 && src_req[(m_rr + n) % 4]) pick = (m_rr + n) % 4;
    if (pick >= 0) begin
      if (src_dst[2*pick +: 2] == 2'd0) lb = !dlv;
      else inj = 1'b1;
    end
    if (lb || inj) m_gnt[pick] = 1'b1;

    chk("i", 64'(i), 64'(m_i));
    chk("rx_valid", 64'(rx_valid), 64'(m_rxv));
    chk("rx_data", 64'(rx_data), 64'(m_rxd));
    chk("busy", 64'(busy), 64'((mq.size() > 0) || m_i[36]));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("src_gnt", 64'(src_gnt), 64'(m_gnt));
    chk("tokens", 64'(dut.tok_q), 64'(m_tok));

    if (rst_n && ce) begin
      refill = (m_rc == 9);
      m_rc   = refill ? 0 : m_rc + 1;
      m_tok  = m_tok + (refill ? 1 : 0) - (inj ? 1 : 0);
      if (m_tok > 8) m_tok = 8;
      if (do_pop) begin
        p   = mq.pop_front();
        m_i = {2'b10, p.a, p.d};
      end else if (inj) m_i = {2'b10, 1'b0, src_dst[2*pick +: 2], src_data[32*pick +: 32]};
      else m_i = '0;
      if (cap) begin
        if (mq.size() < 2) mq.push_back('{a: o[34:32], d: o[31:0]});
        else m_ovf = 1'b1;
      end
      if (do_pop) m_bo = 2;
      else if (m_bo > 0) m_bo--;
      m_rxv = dlv || lb;
      if (dlv) m_rxd = o[31:0];
      else if (lb) m_rxd = src_data[32*pick +: 32];
      if (lb || inj) m_rr = (pick + 1) % 4;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : guard
    #300000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] g [40];
    int ng;
    rst_n = 1'b0; ce = 1'b1; o = '0; src_req = '0; src_dst = '0; src_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset
    cyc(20);
    chk("idle i", 64'(i), 64'd0);
    chk("idle busy", 64'(busy), 64'd0);
    chk("idle ovf", 64'(ovf), 64'd0);
    chk("idle tokens", 64'(dut.tok_q), 64'd8);

    // All sources to dst 2: round-robin until tokens run out, then 1 per 10
    src_req  = 4'b1111;
    src_dst  = 8'b10_10_10_10;
    src_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      g[c] = src_gnt;
      @(posedge clk);
      #1;
    end
    chk("rr g0", 64'(g[0]), 64'h1);
    chk("rr g1", 64'(g[1]), 64'h2);
    chk("rr g2", 64'(g[2]), 64'h4);
    chk("rr g3", 64'(g[3]), 64'h8);
    chk("rr g7", 64'(g[7]), 64'h8);
    chk("empty g8", 64'(g[8]), 64'h0);
    chk("empty g9", 64'(g[9]), 64'h0);
    chk("refill g10", 64'(g[10]), 64'h1);
    ng = 0;
    for (int c = 0; c < 40; c++) if (g[c] != 4'd0) ng++;
    chk("grants in 40", 64'(ng), 64'd11);
    src_req = '0;

    // Clean restart
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    // Capture blocks local grant; second buffered packet 3 cycles later
    o = pk(1'b0, 3'd3, 32'hDEAD0003);
    src_req = 4'b0010;
    @(negedge clk); chk("cap gnt blocked", 64'(src_gnt), 64'h0);
    @(posedge clk); #1 o = pk(1'b0, 3'd1, 32'hDEAD0001);
    @(negedge clk); chk("cap2 gnt", 64'(src_gnt), 64'h0);
    @(posedge clk); #1 o = '0;
    @(negedge clk); chk("reinj p1", 64'(i), 64'({2'b10, 3'd3, 32'hDEAD0003}));
    cyc(1); @(negedge clk); chk("backoff i", 64'(i), 64'd0);
    cyc(1); @(negedge clk); chk("backoff i2", 64'(i), 64'd0);
    cyc(1); @(negedge clk);
    chk("reinj p2", 64'(i), 64'({2'b10, 3'd1, 32'hDEAD0001}));
    chk("local after drain", 64'(src_gnt), 64'h2);
    @(posedge clk); #1 src_req = '0;
    @(negedge clk); chk("local inj", 64'(i), 64'({2'b10, 3'd2, 32'hA1}));
    cyc(5);

    // Overflow: four back-to-back deflected packets, the fourth is dropped
    for (int k = 0; k < 4; k++) begin
      o = pk(1'b1, 3'd0, 32'hF0 + 32'(k));
      if (k < 3) cyc(1);
    end
    @(negedge clk); chk("ovf before", 64'(ovf), 64'd0);
    @(posedge clk); #1 o = '0;
    @(negedge clk); chk("ovf set", 64'(ovf), 64'd1);
    cyc(12);
    chk("ovf sticky", 64'(ovf), 64'd1);

    // Clock enable freeze
    o = pk(1'b1, 3'd2, 32'hDA);
    cyc(1);
    ce = 1'b0; o = pk(1'b1, 3'd1, 32'hDB); src_req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ce0 gnt", 64'(src_gnt), 64'h0);
      chk("ce0 busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    ce = 1'b1; o = '0; src_req = '0;
    cyc(1);
    @(negedge clk); chk("ce1 reinj", 64'(i), 64'({2'b10, 3'd2, 32'hDA}));
    cyc(6);

    // Delivery beats loopback; loopback granted next cycle
    src_dst  = 8'b10_00_10_10;
    src_data = {32'hA3, 32'h77, 32'hA1, 32'hA0};
    src_req  = 4'b0100;
    o = pk(1'b0, 3'd0, 32'h55);
    @(negedge clk); chk("lb blocked", 64'(src_gnt), 64'h0);
    @(posedge clk); #1 o = '0;
    @(negedge clk);
    chk("deliver v", 64'(rx_valid), 64'd1);
    chk("deliver d", 64'(rx_data), 64'h55);
    chk("lb gnt", 64'(src_gnt), 64'h4);
    @(posedge clk); #1 src_req = '0;
    @(negedge clk);
    chk("lb v", 64'(rx_valid), 64'd1);
    chk("lb d", 64'(rx_data), 64'h77);
    chk("lb no slot", 64'(i), 64'd0);
    cyc(1); @(negedge clk); chk("rx idle", 64'(rx_valid), 64'd0);
    cyc(5);

    // Async reset with two packets buffered
    for (int k = 0; k < 3; k++) begin
      o = pk(1'b1, 3'd1, 32'hC0 + 32'(k));
      cyc(1);
    end
    o = '0;
    chk("pre-rst busy", 64'(busy), 64'd1);
    chk("pre-rst ovf", 64'(ovf), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst i", 64'(i), 64'd0);
    chk("rst rx_valid", 64'(rx_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst ovf", 64'(ovf), 64'd0);
    chk("rst tokens", 64'(dut.tok_q), 64'd8);
    cyc(1);
    rst_n = 1'b1;
    cyc(4);
    chk("post-rst busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
